// File: rtl/counter_pkg.sv
// Shared definitions for the bounded up/down counter family.
//   count_mode_e  : wrap to the opposite bound or saturate at the bound
//   next_count()  : next counter value plus wrap flag for one enabled step,
//                   reused by single- and multi-channel counter wrappers.
// Values are carried at CNT_MAX_W bits; narrower counters zero-extend.
package counter_pkg;

    localparam int CNT_MAX_W = 16;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } count_mode_e;

    typedef logic [CNT_MAX_W-1:0] cnt_t;

    typedef struct packed {
        logic wrap;
        cnt_t value;
    } step_result_t;

    // Assumes min_v <= count <= max_v, which the counter keeps invariant
    // (loads are range checked and bound updates clamp the count).
    function automatic step_result_t next_count(
        input cnt_t        count,
        input cnt_t        min_v,
        input cnt_t        max_v,
        input cnt_t        step,
        input logic        up,
        input count_mode_e mode
    );
        step_result_t     r;
        logic [CNT_MAX_W:0] sum;
        r.value = count;
        r.wrap  = 1'b0;
        // One extra bit so the overflow past max_v cannot alias.
        sum = {1'b0, count} + {1'b0, step};
        if (step != '0) begin
            if (up) begin
                if (sum <= {1'b0, max_v}) begin
                    r.value = sum[CNT_MAX_W-1:0];
                end else if (mode == MODE_SAT) begin
                    r.value = max_v;
                end else begin
                    r.value = min_v;
                    r.wrap  = 1'b1;
                end
            end else begin
                // Distance to min_v is compared first, so count - step
                // never underflows.
                if ((count - min_v) >= step) begin
                    r.value = count - step;
                end else if (mode == MODE_SAT) begin
                    r.value = min_v;
                end else begin
                    r.value = max_v;
                    r.wrap  = 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/updown_step_calc.sv
// Combinational next-value / wrap computation for one counter channel.
// Ports:
//   count, min_q, max_q  current value and active bounds (WIDTH)
//   step                 increment per enabled cycle (STEP_W), 0 holds
//   up_down              1 = up, 0 = down
//   mode                 wrap or saturate
//   next_value           value the counter takes if the step is applied
//   wrap                 the step wrapped to the opposite bound
module updown_step_calc
    import counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 2
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [WIDTH-1:0]  min_q,
    input  logic [WIDTH-1:0]  max_q,
    input  logic [STEP_W-1:0] step,
    input  logic              up_down,
    input  count_mode_e       mode,
    output logic [WIDTH-1:0]  next_value,
    output logic              wrap
);

    step_result_t res;
    logic         unused_res;

    assign res = next_count(cnt_t'(count), cnt_t'(min_q), cnt_t'(max_q),
                            cnt_t'(step), up_down, mode);

    assign next_value = res.value[WIDTH-1:0];
    assign wrap       = res.wrap;

    // Bits above WIDTH are always zero since every operand is zero-extended.
    assign unused_res = ^res;

endmodule

// File: rtl/param_updown_counter.sv
// Loadable up/down counter with run-time programmable bounds, variable
// step, wrap or saturate mode and one-cycle status/error pulses.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   en, up_down, step     count enable, direction, increment (0 holds)
//   sat_mode              1 = saturate at bound, 0 = wrap
//   load, load_value      load request, accepted only inside [min_q, max_q]
//   cfg_wr, cfg_min/max   bound update, accepted only if cfg_min <= cfg_max
//   count, min_q, max_q   registered value and active bounds
//   at_min, at_max        count equals the respective bound
//   wrap_pulse, load_err, cfg_err   registered one-cycle pulses
// Request priority per edge: cfg_wr > load > en.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int STEP_W    = 2,
    parameter int RESET_MIN = 2,
    parameter int RESET_MAX = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up_down,
    input  logic              sat_mode,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic              cfg_wr,
    input  logic [WIDTH-1:0]  cfg_min,
    input  logic [WIDTH-1:0]  cfg_max,
    output logic [WIDTH-1:0]  count,
    output logic [WIDTH-1:0]  min_q,
    output logic [WIDTH-1:0]  max_q,
    output logic              at_min,
    output logic              at_max,
    output logic              wrap_pulse,
    output logic              load_err,
    output logic              cfg_err
);

    if (!(RESET_MIN >= 0 && RESET_MIN <= RESET_MAX && RESET_MAX <= 2**WIDTH - 1))
    begin : g_bad_reset_bounds
        $error("param_updown_counter: need 0 <= RESET_MIN <= RESET_MAX <= 2**WIDTH-1");
    end
    if (WIDTH < 1 || WIDTH > CNT_MAX_W || STEP_W < 1 || STEP_W > CNT_MAX_W)
    begin : g_bad_width
        $error("param_updown_counter: WIDTH and STEP_W must be 1..CNT_MAX_W");
    end

    logic [WIDTH-1:0] step_next;
    logic             step_wrap;

    updown_step_calc #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_step_calc (
        .count      (count),
        .min_q      (min_q),
        .max_q      (max_q),
        .step       (step),
        .up_down    (up_down),
        .mode       (count_mode_e'(sat_mode)),
        .next_value (step_next),
        .wrap       (step_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= WIDTH'(RESET_MIN);
            min_q      <= WIDTH'(RESET_MIN);
            max_q      <= WIDTH'(RESET_MAX);
            wrap_pulse <= 1'b0;
            load_err   <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            load_err   <= 1'b0;
            cfg_err    <= 1'b0;
            if (cfg_wr) begin
                if (cfg_min <= cfg_max) begin
                    min_q <= cfg_min;
                    max_q <= cfg_max;
                    // Keep count inside the new window on the same edge.
                    if (count < cfg_min) begin
                        count <= cfg_min;
                    end else if (count > cfg_max) begin
                        count <= cfg_max;
                    end
                end else begin
                    cfg_err <= 1'b1;
                end
            end else if (load) begin
                if (load_value >= min_q && load_value <= max_q) begin
                    count <= load_value;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                count      <= step_next;
                wrap_pulse <= step_wrap;
            end
        end
    end

    assign at_min = (count == min_q);
    assign at_max = (count == max_q);

endmodule

// File: tb/tb_param_updown_counter.sv
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0, up_down = 1'b0, sat_mode = 1'b0;
    logic [1:0] step = '0;
    logic       load = 1'b0;
    logic [3:0] load_value = '0;
    logic       cfg_wr = 1'b0;
    logic [3:0] cfg_min = '0, cfg_max = '0;
    logic [3:0] count, min_q, max_q;
    logic       at_min, at_max, wrap_pulse, load_err, cfg_err;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference state, plain integers.
    int m_cnt, m_min, m_max;
    bit m_wrap, m_lerr, m_cerr;

    param_updown_counter dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .up_down    (up_down),
        .sat_mode   (sat_mode),
        .step       (step),
        .load       (load),
        .load_value (load_value),
        .cfg_wr     (cfg_wr),
        .cfg_min    (cfg_min),
        .cfg_max    (cfg_max),
        .count      (count),
        .min_q      (min_q),
        .max_q      (max_q),
        .at_min     (at_min),
        .at_max     (at_max),
        .wrap_pulse (wrap_pulse),
        .load_err   (load_err),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: range arithmetic on integers.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt = 2; m_min = 2; m_max = 12;
            m_wrap = 0; m_lerr = 0; m_cerr = 0;
        end else begin
            int c, lo, hi, st;
            c = m_cnt; lo = m_min; hi = m_max; st = int'(step);
            m_wrap = 0; m_lerr = 0; m_cerr = 0;
            if (cfg_wr) begin
                if (int'(cfg_min) <= int'(cfg_max)) begin
                    m_min = int'(cfg_min);
                    m_max = int'(cfg_max);
                    if (c < m_min) c = m_min;
                    if (c > m_max) c = m_max;
                    m_cnt = c;
                end else m_cerr = 1;
            end else if (load) begin
                if (int'(load_value) >= lo && int'(load_value) <= hi) m_cnt = int'(load_value);
                else m_lerr = 1;
            end else if (en && st != 0) begin
                if (up_down) begin
                    if (c + st <= hi)  m_cnt = c + st;
                    else if (sat_mode) m_cnt = hi;
                    else begin m_cnt = lo; m_wrap = 1; end
                end else begin
                    if (c - st >= lo)  m_cnt = c - st;
                    else if (sat_mode) m_cnt = lo;
                    else begin m_cnt = hi; m_wrap = 1; end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("count",      int'(count),      m_cnt);
        chk("min_q",      int'(min_q),      m_min);
        chk("max_q",      int'(max_q),      m_max);
        chk("at_min",     int'(at_min),     int'(m_cnt == m_min));
        chk("at_max",     int'(at_max),     int'(m_cnt == m_max));
        chk("wrap_pulse", int'(wrap_pulse), int'(m_wrap));
        chk("load_err",   int'(load_err),   int'(m_lerr));
        chk("cfg_err",    int'(cfg_err),    int'(m_cerr));
    end

    // Apply one cycle of inputs; returns 2 time units after the edge.
    task automatic drive(input bit e, input bit ud, input bit sm, input int st,
                         input bit ld, input int lv,
                         input bit cw, input int cmn, input int cmx);
        en = e; up_down = ud; sat_mode = sm; step = 2'(st);
        load = ld; load_value = 4'(lv);
        cfg_wr = cw; cfg_min = 4'(cmn); cfg_max = 4'(cmx);
        @(posedge clk);
        #2;
        en = 0; load = 0; cfg_wr = 0;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        chk("rst_count", int'(count), 2);
        chk("rst_min",   int'(min_q), 2);
        chk("rst_max",   int'(max_q), 12);
        chk("rst_at_min", int'(at_min), 1);
        chk("rst_at_max", int'(at_max), 0);
        chk("rst_pulses", int'({wrap_pulse, load_err, cfg_err}), 0);
        idle();

        // Wrap up from 11, step 1.
        drive(0, 0, 0, 0, 1, 11, 0, 0, 0);
        chk("ld11", int'(count), 11);
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
        chk("up_12", int'(count), 12);
        chk("up_12_atmax", int'(at_max), 1);
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
        chk("wrap_2", int'(count), 2);
        chk("wrap_2_pulse", int'(wrap_pulse), 1);
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0);
        chk("up_3", int'(count), 3);
        chk("up_3_pulse", int'(wrap_pulse), 0);

        // Saturate down from 4, step 3.
        drive(0, 0, 0, 0, 1, 4, 0, 0, 0);
        drive(1, 0, 1, 3, 0, 0, 0, 0, 0);
        chk("sat_2", int'(count), 2);
        drive(1, 0, 1, 3, 0, 0, 0, 0, 0);
        chk("sat_2_hold", int'(count), 2);
        chk("sat_nopulse", int'(wrap_pulse), 0);

        // Wrap down: 3 - 2 leaves window only at 2 -> 3-2=1 < min.
        drive(0, 0, 0, 0, 1, 3, 0, 0, 0);
        drive(1, 0, 0, 2, 0, 0, 0, 0, 0);
        chk("wrapdn_12", int'(count), 12);
        chk("wrapdn_pulse", int'(wrap_pulse), 1);
        drive(1, 0, 0, 3, 0, 0, 0, 0, 0);
        chk("dn_9", int'(count), 9);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("step0_hold", int'(count), 9);

        // Load rejection and acceptance.
        drive(0, 0, 0, 0, 1, 13, 0, 0, 0);
        chk("ld13_hold", int'(count), 9);
        chk("ld13_err", int'(load_err), 1);
        idle();
        chk("lerr_1cyc", int'(load_err), 0);
        drive(0, 0, 0, 0, 1, 2, 0, 0, 0);
        chk("ld2", int'(count), 2);
        chk("ld2_noerr", int'(load_err), 0);
        drive(0, 0, 0, 0, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 0, 0, 0);
        chk("ld1_b2b_err", int'(load_err), 1);

        // Config update with clamp, then rejected config.
        drive(0, 0, 0, 0, 1, 10, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 3, 7);
        chk("cfg_min3", int'(min_q), 3);
        chk("cfg_max7", int'(max_q), 7);
        chk("cfg_clamp7", int'(count), 7);
        drive(0, 0, 0, 0, 0, 0, 1, 9, 5);
        chk("cfg_bad_err", int'(cfg_err), 1);
        chk("cfg_bad_min", int'(min_q), 3);
        chk("cfg_bad_max", int'(max_q), 7);

        // cfg + load + en together: only cfg applies.
        drive(1, 1, 0, 1, 1, 5, 1, 4, 6);
        chk("simul_count", int'(count), 6);
        chk("simul_lerr", int'(load_err), 0);
        // load + en: load wins.
        drive(1, 1, 0, 3, 1, 4, 0, 0, 0);
        chk("ld_over_en", int'(count), 4);

        // Degenerate span: constant count, wrap pulses every enabled step.
        drive(0, 0, 0, 0, 0, 0, 1, 5, 5);
        chk("deg_count", int'(count), 5);
        drive(1, 1, 0, 2, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("deg_wrap", int'(wrap_pulse), 1);
        chk("deg_hold", int'(count), 5);
        drive(1, 1, 1, 3, 0, 0, 0, 0, 0);
        chk("deg_sat_nopulse", int'(wrap_pulse), 0);

        // Widen window, low bound raising clamp, then async reset mid-count.
        drive(0, 0, 0, 0, 0, 0, 1, 0, 15);
        drive(1, 1, 0, 3, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 3, 0, 0, 0, 0, 0);
        chk("full_11", int'(count), 11);
        drive(0, 0, 0, 0, 0, 0, 1, 13, 14);
        chk("clamp_up_13", int'(count), 13);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 15);
        en = 1; up_down = 1; step = 2'd1;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_count", int'(count), 2);
        chk("async_rst_max", int'(max_q), 12);
        en = 0; step = 2'd0;
        @(posedge clk);
        #2 reset = 1'b0;
        idle();
        chk("post_rst_count", int'(count), 2);
        repeat (2) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/param_updown_counter.md
# param_updown_counter

Parametrised loadable up/down counter with run-time programmable bounds, variable step, wrap or saturate mode, and status/error flags. Serves as the general bounded-counter primitive for sequencing, address stepping and timeout logic. Replaces fixed-bound 4-bit counters: it is one instance per channel, with bounds set through a configuration strobe.

## Interface
Parameters:
- WIDTH, 4, count and bound width
- STEP_W, 2, step input width
- RESET_MIN, 2, lower bound after reset
- RESET_MAX, 12, upper bound after reset
- Elaboration check: RESET_MIN <= RESET_MAX <= 2**WIDTH-1.

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- en  in  1  count enable
- up_down  in  1  1 = count up, 0 = count down
- sat_mode  in  1  1 = saturate at bound, 0 = wrap to opposite bound
- step  in  STEP_W  increment per enabled cycle; 0 holds
- load  in  1  load request
- load_value  in  WIDTH  value to load
- cfg_wr  in  1  bound update strobe
- cfg_min, cfg_max  in  WIDTH  new bounds
- count  out  WIDTH  registered counter value
- min_q, max_q  out  WIDTH  active bounds
- at_min, at_max  out  1  count == min_q / count == max_q
- wrap_pulse  out  1  one-cycle pulse when a wrap occurred
- load_err  out  1  one-cycle pulse when a load was rejected
- cfg_err  out  1  one-cycle pulse when a config was rejected

## Operation
- Priority at each edge: cfg_wr > load > en. A lower-priority request in the same cycle is dropped silently, with no error pulse.
- cfg_wr:
  - Accepted if cfg_min <= cfg_max. min_q and max_q update.
  - If count lies outside the new bounds, count clamps to the nearest new bound on the same edge.
  - Otherwise bounds are unchanged and cfg_err pulses.
- load:
  - If min_q <= load_value <= max_q, count <= load_value.
  - Otherwise count holds and load_err pulses.
- en with step = 0: count holds.
- Up count:
  - Compute sum = count + step in WIDTH+1 bits.
  - If sum <= max_q, count <= sum.
  - Else if sat_mode, count <= max_q with no pulse.
  - Else count <= min_q and wrap_pulse fires.
- Down count:
  - If count - min_q >= step, count <= count - step. No underflow is possible.
  - Else if sat_mode, count <= min_q.
  - Else count <= max_q and wrap_pulse fires.
- Degenerate span (min_q == max_q): count stays constant. Wrap mode still pulses wrap_pulse on every enabled non-zero step.
- en = 0 and no load or cfg: all state holds and pulses are 0.

## Timing
- Reset (asynchronous assert, released on clk domain):
  - count = RESET_MIN, min_q = RESET_MIN, max_q = RESET_MAX.
  - wrap_pulse, load_err and cfg_err = 0.
  - at_min = 1; at_max = (RESET_MIN == RESET_MAX).
- Latency: one cycle from request to updated count. wrap_pulse, load_err and cfg_err are registered and assert in the same cycle the resulting count is visible.
- at_min and at_max are combinational compares of registered values, so they have no extra latency.
- Reset mid-operation overrides everything immediately. No pending request survives reset.
- Back-to-back requests on consecutive cycles are each honoured. Pulses do not stretch.

## Structure
- Shared package counter_pkg:
  - typedef count_mode_e (MODE_WRAP = 0, MODE_SAT = 1)
  - function next_count(count, min, max, step, up, mode), returning next value plus wrap flag, reused by multi-channel wrappers
- Sub-module updown_step_calc: purely combinational next-value/wrap computation. The top level holds the registers, priority logic and error pulses.

## Test plan
All scenarios use default parameters.
- Reset released -> count = 2, min_q = 2, max_q = 12, at_min = 1, all pulses 0.
- Wrap, up: load 11, then en with up_down = 1, step = 1, sat_mode = 0 for 3 cycles -> count 12, 2 (wrap_pulse = 1 that cycle), 3.
- Saturate, down: load 4, then step = 3, up_down = 0, sat_mode = 1 for 2 cycles -> count 2, then 2 held, wrap_pulse never 1.
- Load rejection: load_value = 13 -> count unchanged, load_err pulses for 1 cycle. load_value = 2 -> accepted, no error.
- Config:
  - With count = 10, cfg_wr with min = 3, max = 7 -> bounds updated and count clamps to 7.
  - cfg_wr with min = 9, max = 5 -> cfg_err pulses, bounds stay 3/7.
- Simultaneous events: cfg_wr + load + en in one cycle -> only cfg applied. Reset asserted mid-count, asynchronous to clk -> count = 2 immediately.
